// File: rtl/da_fir_engine.sv
// Bit-serial distributed-arithmetic FIR engine for 8 taps. It walks the delay-line
// bits LSB first, addresses an external combinational coefficient LUT, and accumulates the partial sums.
module da_fir_engine #(
  parameter int DATA_W = 16,
  parameter int LUT_W  = 32,
  localparam int OUT_W = LUT_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        lut_addr,
  input  logic [LUT_W-1:0]  lut_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_W-1:0]       taps [8];
  logic signed [OUT_W-1:0] acc;
  logic signed [OUT_W-1:0] addend;
  logic                    last_bit;

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  // The LUT word is sign-extended to the full accumulator width before the bit weight is applied.
  assign addend = {{DATA_W{lut_data[LUT_W-1]}}, lut_data} << bit_cnt;

  always_comb begin
    lut_addr = '0;
    if (state == CALC) begin
      for (int i = 0; i < 8; i++) begin
        lut_addr[i] = taps[i][bit_cnt];
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      acc     <= '0;
      for (int i = 0; i < 8; i++) begin
        taps[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 7; i > 0; i--) begin
              taps[i] <= taps[i-1];
            end
            taps[0] <= in_data;
            acc     <= '0;
            bit_cnt <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          // The sign bit of a two's-complement sample carries negative weight.
          if (last_bit) begin
            acc     <= acc - addend;
            bit_cnt <= '0;
            state   <= DONE;
          end else begin
            acc     <= acc + addend;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_da_fir_engine.sv
// Directed bench for da_fir_engine with the 8-tap LUT b = 1,1,-5,-12,22,39,-62,-94.
// Table-driven sample/result vectors plus hand-written latency, backpressure and reset sequences.
module tb_da_fir_engine;

  localparam int DATA_W = 16;
  localparam int LUT_W  = 32;
  localparam int OUT_W  = 48;
  localparam int COEF [8] = '{1, 1, -5, -12, 22, 39, -62, -94};

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        lut_addr;
  logic [LUT_W-1:0]  lut_data;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;

  int checks;
  int errors;

  typedef struct {
    logic                     do_reset;
    logic signed [DATA_W-1:0] din;
    logic signed [OUT_W-1:0]  expected;
  } vec_t;

  vec_t vecs [22];

  da_fir_engine dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .lut_addr(lut_addr),
    .lut_data(lut_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational DA LUT: the sum of the coefficients whose address bit is set.
  always_comb begin
    logic signed [LUT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      if (lut_addr[i]) sum = sum + LUT_W'(COEF[i]);
    end
    lut_data = sum;
  end

  task automatic checkOutput(input string name, input logic signed [OUT_W-1:0] actual,
                             input logic signed [OUT_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one sample, wait for its result and complete the output handshake.
  task automatic applyStimulus(input logic [DATA_W-1:0] din, output logic signed [OUT_W-1:0] result);
    int n;
    result = '0;
    @(negedge clk);
    in_data  = din;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 48'sd0, 48'sd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checkOutput("result_timeout", 48'sd0, 48'sd1);
      return;
    end
    result = $signed(out_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic signed [OUT_W-1:0] res;
    logic signed [OUT_W-1:0] held;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Impulse response
    vecs[0]  = '{1'b1, 16'sd1, 48'sd1};
    vecs[1]  = '{1'b0, 16'sd0, 48'sd1};
    vecs[2]  = '{1'b0, 16'sd0, -48'sd5};
    vecs[3]  = '{1'b0, 16'sd0, -48'sd12};
    vecs[4]  = '{1'b0, 16'sd0, 48'sd22};
    vecs[5]  = '{1'b0, 16'sd0, 48'sd39};
    vecs[6]  = '{1'b0, 16'sd0, -48'sd62};
    vecs[7]  = '{1'b0, 16'sd0, -48'sd94};
    // Negative full scale
    vecs[8]  = '{1'b1, 16'h8000, -48'sd32768};
    vecs[9]  = '{1'b0, 16'sd0, -48'sd32768};
    // Positive full-scale step: running coefficient sums times 32767
    vecs[10] = '{1'b1, 16'sd32767, 48'sd32767};
    vecs[11] = '{1'b0, 16'sd32767, 48'sd65534};
    vecs[12] = '{1'b0, 16'sd32767, -48'sd98301};
    vecs[13] = '{1'b0, 16'sd32767, -48'sd491505};
    vecs[14] = '{1'b0, 16'sd32767, 48'sd229369};
    vecs[15] = '{1'b0, 16'sd32767, 48'sd1507282};
    vecs[16] = '{1'b0, 16'sd32767, -48'sd524272};
    vecs[17] = '{1'b0, 16'sd32767, -48'sd3604370};
    vecs[18] = '{1'b0, 16'sd32767, -48'sd3604370};
    // Mixed signs: 3, -2, 100
    vecs[19] = '{1'b1, 16'sd3, 48'sd3};
    vecs[20] = '{1'b0, -16'sd2, 48'sd1};
    vecs[21] = '{1'b0, 16'sd100, 48'sd83};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", {47'd0, in_ready}, 48'sd1);
    checkOutput("reset_out_valid", {47'd0, out_valid}, 48'sd0);
    checkOutput("reset_out_data", $signed(out_data), 48'sd0);
    checkOutput("reset_lut_addr", {40'd0, lut_addr}, 48'sd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 22; v++) begin
      if (vecs[v].do_reset) doReset();
      applyStimulus(vecs[v].din, res);
      checkOutput($sformatf("vec%0d", v), res, vecs[v].expected);
    end

    // Latency: in_valid held high from reset release; accept at the first edge.
    doReset();
    in_data  = 16'sd5;
    in_valid = 1'b1;
    checkOutput("lat_ready_c0", {47'd0, in_ready}, 48'sd1);
    @(posedge clk);
    #1;
    checkOutput("lat_ready_c1", {47'd0, in_ready}, 48'sd0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("lat_ready_c%0d", k + 1), {47'd0, in_ready}, 48'sd0);
      checkOutput($sformatf("lat_valid_c%0d", k + 1), {47'd0, out_valid}, (k == 16) ? 48'sd1 : 48'sd0);
    end
    checkOutput("lat_data", $signed(out_data), 48'sd5);
    @(posedge clk);
    #1;
    checkOutput("lat_ready_c18", {47'd0, in_ready}, 48'sd1);
    checkOutput("lat_valid_c18", {47'd0, out_valid}, 48'sd0);
    @(posedge clk);
    #1;
    checkOutput("lat_second_accept", {47'd0, in_ready}, 48'sd0);
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    checkOutput("lat_second_valid", {47'd0, out_valid}, 48'sd1);
    checkOutput("lat_second_data", $signed(out_data), 48'sd10);

    // Backpressure: result must hold for five cycles with out_ready low.
    doReset();
    out_ready = 1'b0;
    in_data   = 16'sd7;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    checkOutput("bp_valid_rise", {47'd0, out_valid}, 48'sd1);
    held = $signed(out_data);
    checkOutput("bp_data", held, 48'sd7);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_valid", {47'd0, out_valid}, 48'sd1);
      checkOutput("bp_hold_data", $signed(out_data), 48'sd7);
      checkOutput("bp_hold_ready", {47'd0, in_ready}, 48'sd0);
      checkOutput("bp_hold_addr", {40'd0, lut_addr}, 48'sd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", {47'd0, out_valid}, 48'sd0);
    checkOutput("bp_release_ready", {47'd0, in_ready}, 48'sd1);
    @(posedge clk);
    #1;
    checkOutput("bp_single_hs", {47'd0, out_valid}, 48'sd0);

    // Reset during CALC at bit 7 of a 32767 sample.
    doReset();
    in_data  = 16'sd32767;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("mid_addr_bit0", {40'd0, lut_addr}, 48'sd1);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("mid_addr_bit7", {40'd0, lut_addr}, 48'sd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_ready", {47'd0, in_ready}, 48'sd1);
    checkOutput("mid_rst_valid", {47'd0, out_valid}, 48'sd0);
    checkOutput("mid_rst_addr", {40'd0, lut_addr}, 48'sd0);
    checkOutput("mid_rst_data", $signed(out_data), 48'sd0);
    rst = 1'b0;
    applyStimulus(16'sd1, res);
    checkOutput("mid_rst_cleared", res, 48'sd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
